booth_divider_seq: RTL and testbench

- Sequential signed integer divider. It is the inverse-operation companion to the combinational 32x32 signed multiplier in the ALU.
- Takes 32-bit signed dividend and divisor. Produces a 64-bit result packed the same way the multiply result is consumed: HI = remainder, LO = quotient.
- Uses radix-2 restoring division on magnitudes, with a final sign fix-up step.
- Fixed latency, with a start/busy/done handshake to the CPU control unit.

---
 rtl/booth_divider_seq.sv | 120 ++++++++++++
 tb/tb_booth_divider_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/booth_divider_seq.sv
// Sequential signed divider: radix-2 restoring division on operand magnitudes,
// one quotient bit per clock, then a sign fix-up producing {remainder, quotient}.
module booth_divider_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               div_by_zero
);

  // Handshake: start is accepted only in IDLE; busy stays high from the
  // accepting edge until the edge that raises done, and done is a one-cycle
  // pulse while result/div_by_zero stay valid until the next accepted start.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FIXUP = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0] cnt;
  // The partial remainder is always below the divisor, so WIDTH bits hold it;
  // the extra trial bit only exists in the combinational subtract.
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] dvd_raw_q;
  logic             sign_q;
  logic             sign_r;
  logic             zero_flag;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic             last_iter;

  always_comb begin
    dvd_mag   = dividend[WIDTH-1] ? -dividend : dividend;
    dvs_mag   = divisor[WIDTH-1]  ? -divisor  : divisor;
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    trial     = rem_shift - {1'b0, dvs_q};
    quo_fix   = sign_q ? -quo_q : quo_q;
    rem_fix   = sign_r ? -rem_q : rem_q;
    last_iter = (cnt == CNT_W'(WIDTH - 1));
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ITER;
      ITER:    if (last_iter) state_next = FIXUP;
      FIXUP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      cnt         <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      dvd_raw_q   <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      zero_flag   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign_q    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            sign_r    <= dividend[WIDTH-1];
            quo_q     <= dvd_mag;
            dvs_q     <= dvs_mag;
            dvd_raw_q <= dividend;
            rem_q     <= '0;
            cnt       <= '0;
            zero_flag <= (divisor == '0);
            busy      <= 1'b1;
          end
        end
        ITER: begin
          // Negative trial means the divisor did not fit: restore (keep the shift).
          rem_q <= trial[WIDTH] ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
          quo_q <= {quo_q[WIDTH-2:0], ~trial[WIDTH]};
          if (!last_iter) cnt <= cnt + CNT_W'(1);
        end
        FIXUP: begin
          result      <= zero_flag ? {dvd_raw_q, {WIDTH{1'b1}}} : {rem_fix, quo_fix};
          div_by_zero <= zero_flag;
          done        <= 1'b1;
          busy        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_divider_seq.sv
// Self-checking bench for booth_divider_seq: directed cases plus randomized
// operands checked against a plain-arithmetic signed division model.
module tb_booth_divider_seq;
  localparam int W = 32;
  localparam int LAT = 33;

  logic           clock = 1'b0;
  logic           clear;
  logic           start;
  logic [W-1:0]   dividend;
  logic [W-1:0]   divisor;
  logic           busy;
  logic           done;
  logic [2*W-1:0] result;
  logic           div_by_zero;

  int errors = 0;
  int checks = 0;
  logic [2*W:0] exp_q[$];

  booth_divider_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clock(clock),
    .clear(clear),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .result(result),
    .div_by_zero(div_by_zero)
  );

  always #5 clock = ~clock;

  // Reference: {div_by_zero, remainder, quotient} from 64-bit signed arithmetic.
  function automatic logic [2*W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, q, r;
    logic [63:0] qv, rv;
    if (b == 0) return {1'b1, a, {W{1'b1}}};
    sa = $signed(a);
    sb = $signed(b);
    q  = sa / sb;
    r  = sa % sb;
    qv = q;
    rv = r;
    return {1'b0, rv[W-1:0], qv[W-1:0]};
  endfunction

  // Pulses start for one edge, scrambles operands afterwards, and counts edges
  // from acceptance until done (bounded at 100).
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int busy_n);
    @(negedge clock);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clock);
    start = 1'b0; dividend = $urandom; divisor = $urandom;
    lat = 0; busy_n = 0;
    while (!done && lat < 100) begin
      if (busy) busy_n++;
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic test_reset;
    clear = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (result !== '0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
    clear = 1'b0;
  endtask

  task automatic test_positive;
    int lat, bn;
    run_div(32'd7, 32'd2, lat, bn);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL pos_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (bn !== LAT) begin errors++; $display("FAIL pos_busy_cycles: got %0d expected %0d", bn, LAT); end
    checks++; if (result !== 64'h00000001_00000003) begin errors++; $display("FAIL pos_result: got %h expected 0000000100000003", result); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL pos_dbz: got %b expected 0", div_by_zero); end
    @(negedge clock);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL pos_done_pulse: got %b expected 0", done); end
    checks++; if (result !== 64'h00000001_00000003) begin errors++; $display("FAIL pos_result_hold: got %h expected 0000000100000003", result); end
  endtask

  task automatic test_signs;
    logic [W-1:0]   a_tab[3] = '{-32'sd7, 32'd7, -32'sd7};
    logic [W-1:0]   b_tab[3] = '{32'd2, -32'sd2, -32'sd2};
    logic [2*W-1:0] e_tab[3] = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000001_FFFFFFFD, 64'hFFFFFFFF_00000003};
    int lat, bn;
    for (int i = 0; i < 3; i++) begin
      run_div(a_tab[i], b_tab[i], lat, bn);
      checks++; if (result !== e_tab[i]) begin errors++; $display("FAIL signs_%0d: got %h expected %h", i, result, e_tab[i]); end
      checks++; if (lat !== LAT) begin errors++; $display("FAIL signs_lat_%0d: got %0d expected %0d", i, lat, LAT); end
    end
  endtask

  task automatic test_overflow;
    int lat, bn;
    run_div(32'h80000000, 32'hFFFFFFFF, lat, bn);
    checks++; if (result !== 64'h00000000_80000000) begin errors++; $display("FAIL ovf_result: got %h expected 0000000080000000", result); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL ovf_dbz: got %b expected 0", div_by_zero); end
  endtask

  task automatic test_div_by_zero;
    int lat, bn;
    run_div(32'd5, 32'd0, lat, bn);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL dbz_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (result !== 64'h00000005_FFFFFFFF) begin errors++; $display("FAIL dbz_result: got %h expected 00000005ffffffff", result); end
    checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_flag: got %b expected 1", div_by_zero); end
    @(negedge clock);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL dbz_done_once: got %b expected 0", done); end
    checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_flag_hold: got %b expected 1", div_by_zero); end
    run_div(32'd6, 32'd3, lat, bn);
    checks++; if (result !== 64'h00000000_00000002) begin errors++; $display("FAIL dbz_next_result: got %h expected 0000000000000002", result); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL dbz_next_flag: got %b expected 0", div_by_zero); end
  endtask

  task automatic test_random;
    logic [W-1:0] a, b;
    logic [2*W:0] exp;
    int lat, bn;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom;
        1:       b = $urandom_range(1, 20);
        2:       b = -$urandom_range(1, 20);
        default: b = (i % 8 == 3) ? '0 : $urandom_range(1, 3);
      endcase
      exp_q.push_back(ref_div(a, b));
      run_div(a, b, lat, bn);
      exp = exp_q.pop_front();
      checks++; if (result !== exp[2*W-1:0]) begin errors++; $display("FAIL rand_result %h/%h: got %h expected %h", a, b, result, exp[2*W-1:0]); end
      checks++; if (div_by_zero !== exp[2*W]) begin errors++; $display("FAIL rand_dbz %h/%h: got %b expected %b", a, b, div_by_zero, exp[2*W]); end
      checks++; if (lat !== LAT) begin errors++; $display("FAIL rand_latency: got %0d expected %0d", lat, LAT); end
    end
  endtask

  task automatic test_back_to_back;
    int n;
    logic [W-1:0] a2, b2;
    logic [2*W:0] exp;
    @(negedge clock);
    start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      if (n == 9) begin start = 1'b1; dividend = 32'd1; divisor = 32'd1; end
      else start = 1'b0;
      @(negedge clock);
      n++;
    end
    checks++; if (n !== LAT) begin errors++; $display("FAIL hs_latency: got %0d expected %0d", n, LAT); end
    checks++; if (result !== 64'h00000002_0000000E) begin errors++; $display("FAIL hs_ignore_start: got %h expected 000000020000000e", result); end
    // Start raised during the done cycle must launch the next divide.
    a2 = $urandom; b2 = $urandom_range(1, 1000);
    exp_q.push_back(ref_div(a2, b2));
    start = 1'b1; dividend = a2; divisor = b2;
    @(negedge clock);
    start = 1'b0; dividend = $urandom; divisor = $urandom;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_drop: got %b expected 0", done); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b expected 1", busy); end
    n = 0;
    while (!done && n < 100) begin
      @(negedge clock);
      n++;
    end
    exp = exp_q.pop_front();
    checks++; if (n !== LAT) begin errors++; $display("FAIL b2b_latency: got %0d expected %0d", n, LAT); end
    checks++; if (result !== exp[2*W-1:0]) begin errors++; $display("FAIL b2b_result: got %h expected %h", result, exp[2*W-1:0]); end
  endtask

  task automatic test_reset_mid;
    int lat, bn;
    bit seen;
    @(negedge clock);
    start = 1'b1; dividend = 32'd123; divisor = 32'd4;
    @(negedge clock);
    start = 1'b0;
    repeat (14) @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_done: got %b expected 0", done); end
    checks++; if (result !== '0) begin errors++; $display("FAIL mid_result: got %h expected 0", result); end
    clear = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (done) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_no_done: got %b expected 0", seen); end
    run_div(32'd9, 32'd3, lat, bn);
    checks++; if (result !== 64'h00000000_00000003) begin errors++; $display("FAIL mid_fresh_result: got %h expected 0000000000000003", result); end
    checks++; if (lat !== LAT) begin errors++; $display("FAIL mid_fresh_latency: got %0d expected %0d", lat, LAT); end
  endtask

  initial begin
    test_reset();
    test_positive();
    test_signs();
    test_overflow();
    test_div_by_zero();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
